pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor: next generation of our registered
//  4-bit CLA. Operands split into BLOCK-bit lookahead groups; one group resolved per pipeline

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_block.sv | 44 ++++
 rtl/pipelined_cla_adder.sv | 92 +++++++++
 tb/tb_pipelined_cla_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, default stage record and reference group-add math for the pipelined CLA.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_BLOCK = 4;

  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] a_hi;
    logic [CLA_WIDTH-1:0] b_hi;
    logic [CLA_WIDTH-1:0] sum_lo;
    logic                 carry;
  } cla_stage_t;

  // Plain arithmetic reference for one group: returns {cout, sum}.
  function automatic logic [CLA_BLOCK:0] cla_group(input logic [CLA_BLOCK-1:0] a,
                                                   input logic [CLA_BLOCK-1:0] b,
                                                   input logic                 cin);
    return {1'b0, a} + {1'b0, b} + {{CLA_BLOCK{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational carry-lookahead group: g/p, fully expanded lookahead carries, sum bits.
module cla_block
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // c[i+1] = cin&p[0..i] | OR_j (g[j] & p[j+1..i]) -- no ripple through c[i]
  always_comb begin
    logic term;
    term   = 1'b0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      term = i_cin;
      for (int unsigned j = 0; j <= i; j++) term = term & w_p[j];
      w_c[i+1] = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = w_g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & w_p[m];
        w_c[i+1] = w_c[i+1] | term;
      end
    end
  end

  assign o_sum  = w_p ^ w_c[BLOCK-1:0];
  assign o_cout = w_c[BLOCK];
  assign o_cmsb = w_c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one BLOCK-bit group per stage, valid/ready on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned STAGES = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
  } stage_t;

  stage_t r_stg  [STAGES];
  stage_t w_nxt  [STAGES];
  logic   w_cmsb [STAGES];
  logic   r_ovf;
  logic   w_adv;

  assign w_adv    = ~r_stg[STAGES-1].valid | out_ready;
  assign in_ready = w_adv & rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_cur;
    logic [BLOCK-1:0] w_gsum;
    logic             w_gcout;
    logic [WIDTH-1:0] w_slo;

    if (k == 0) begin : g_head
      assign w_cur = {in_valid, in_a, (in_sub ? ~in_b : in_b), {WIDTH{1'b0}},
                      (in_sub ? ~in_cin : in_cin)};
    end else begin : g_body
      assign w_cur = r_stg[k-1];
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .i_a    (w_cur.a_hi[k*BLOCK +: BLOCK]),
      .i_b    (w_cur.b_hi[k*BLOCK +: BLOCK]),
      .i_cin  (w_cur.carry),
      .o_sum  (w_gsum),
      .o_cout (w_gcout),
      .o_cmsb (w_cmsb[k])
    );

    always_comb begin
      w_slo                    = w_cur.sum_lo;
      w_slo[k*BLOCK +: BLOCK]  = w_gsum;
    end

    assign w_nxt[k] = {w_cur.valid, w_cur.a_hi, w_cur.b_hi, w_slo, w_gcout};
  end

  // The last stage register doubles as the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) r_stg[k] <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) r_stg[k] <= w_nxt[k];
      r_ovf <= w_cmsb[STAGES-1] ^ w_nxt[STAGES-1].carry;
    end
  end

  assign out_valid = r_stg[STAGES-1].valid;
  assign out_sum   = r_stg[STAGES-1].sum_lo;
  assign out_cout  = r_stg[STAGES-1].carry;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector and scoreboard bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned B   = 4;
  localparam int          LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_cin, in_sub;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit strict    = 1'b1;
  bit rnd_ready = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W+1:0] res;
    int           cyc;
  } exp_t;

  exp_t q[$];
  vec_t vecs[7];

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Returns {ovf, cout, sum}; ovf from operand/result signs, independent of carries.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] beff, sum;
    logic         c, ovf;
    logic [B:0]   r;
    beff = sub ? ~b : b;
    c    = sub ? ~cin : cin;
    sum  = '0;
    for (int g = 0; g < int'(W / B); g++) begin
      r = cla_group(a[g*B +: B], beff[g*B +: B], c);
      sum[g*B +: B] = r[B-1:0];
      c = r[B];
    end
    ovf = (a[W-1] == beff[W-1]) && (sum[W-1] != a[W-1]);
    return {ovf, c, sum};
  endfunction

  // Scoreboard: both handshakes are sampled on the falling edge, transfer on the next rise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=0x%0h required=none cycle=%0d", out_sum, cyc);
        end else begin
          e = q.pop_front();
          chk("sb_result", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, e.res});
          if (strict) chk("sb_latency", cyc - e.cyc, LAT);
        end
      end
      if (in_valid && in_ready) begin
        e.res = model(in_a, in_b, in_cin, in_sub);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int n;
    bit ok;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      n++;
    end
    chk("accept_within_bound", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] hold, exp;
    int n;

    vecs[0] = '{16'h0009, 16'h000D, 1'b0, 1'b0, 16'h0016, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h000A, 16'h0005, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      chk("vec_in_ready", in_ready, 1);
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      repeat (2) @(posedge clk);
      #1;
      chk("vec_not_early", out_valid, 0);
      @(posedge clk); #1;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_sum", out_sum, vecs[i].sum);
      chk("vec_cout", out_cout, vecs[i].cout);
      chk("vec_ovf", out_ovf, vecs[i].ovf);
      @(posedge clk); #1;
    end

    // Streaming: 8 back-to-back beats, each must show latency exactly LAT.
    for (int i = 0; i < 8; i++)
      send(16'h1111 * i[15:0], 16'h0F0F ^ i[15:0], i[1], i[0]);
    drain();

    // Backpressure: freeze output for 3 cycles mid-stream.
    strict = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(16'hA5A5 + i[15:0], 16'h3C3C - i[15:0], i[0], i[1]);
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_out_valid_seen", out_valid, 1);
        out_ready = 1'b0;
        hold = {out_ovf, out_cout, out_sum};
        repeat (3) begin
          @(posedge clk); #1;
          chk("bp_valid_held", out_valid, 1);
          chk("bp_data_frozen", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, hold});
          chk("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    strict = 1'b1;

    // Reset with 3 beats in flight: none may emerge, next beat has full latency.
    for (int i = 0; i < 3; i++) send(16'h0100 + i[15:0], 16'h0011, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_flushed", out_valid, 0);
    end
    exp = model(16'h4321, 16'h1111, 1'b1, 1'b1);
    send(16'h4321, 16'h1111, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("midrst_latency", out_valid, 1);
    chk("midrst_sum", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, exp});
    drain();

    // Random traffic against the scoreboard.
    strict    = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
